// File: rtl/blowfish128_pkg.sv
// Shared types and constants for the Blowfish-128 stream controller.
package blowfish128_pkg;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int REST_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_REST  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/blowfish128_stream_ctrl.sv
// Packs a 32-bit word stream into 128-bit blocks for a sibling Blowfish core and
// unpacks each result back into a word stream, MSW first.
//
// state | meaning
// FILL  | collecting 4 input words; key writes accepted here only
// RUN   | core enabled, inputs held, waiting for core_ready
// REST  | core disabled for REST_CYCLES before the next use
// DRAIN | presenting 4 result words on the output stream
module blowfish128_stream_ctrl
    import blowfish128_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter int REST_CYCLES = REST_CYCLES_DEF
) (
    input  logic                                Clk,
    input  logic                                RstN,
    input  logic [WORD_W-1:0]                   in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                mode_encrypt,
    input  logic                                key_wr_en,
    input  logic [2:0]                          key_wr_idx,
    input  logic [63:0]                         key_wr_data,
    input  logic [3:0]                          key_len_in,
    output logic                                core_enable,
    output logic                                core_encrypt,
    output logic [WORDS_PER_BLOCK*WORD_W-1:0]   core_plaintext,
    output logic [63:0]                         core_key0,
    output logic [63:0]                         core_key1,
    output logic [63:0]                         core_key2,
    output logic [63:0]                         core_key3,
    output logic [63:0]                         core_key4,
    output logic [63:0]                         core_key5,
    output logic [63:0]                         core_key6,
    output logic [63:0]                         core_key7,
    output logic [3:0]                          core_key_length,
    input  logic [WORDS_PER_BLOCK*WORD_W-1:0]   core_ciphertext,
    input  logic                                core_ready,
    output logic [WORD_W-1:0]                   out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                busy
);

    localparam int         BLK_W     = WORDS_PER_BLOCK * WORD_W;
    localparam int         RW        = (REST_CYCLES > 1) ? $clog2(REST_CYCLES) : 1;
    localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_BLOCK - 1);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [RW-1:0]     rest_q, rest_d;
    logic              mode_q;
    logic [3:0]        key_len_q;
    logic [WORD_W-1:0] blk_q [WORDS_PER_BLOCK];
    logic [WORD_W-1:0] res_q [WORDS_PER_BLOCK];
    logic [63:0]       key_q [8];
    logic              fill_acc, run_cap, key_wr_ok;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rest_d      = rest_q;
        in_ready    = 1'b0;
        core_enable = 1'b0;
        out_valid   = 1'b0;
        fill_acc    = 1'b0;
        run_cap     = 1'b0;
        key_wr_ok   = 1'b0;
        case (state_q)
            ST_FILL: begin
                // Held low while reset is asserted so no word is taken during reset.
                in_ready  = RstN;
                fill_acc  = in_valid && RstN;
                key_wr_ok = key_wr_en;
                if (fill_acc) begin
                    if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            ST_RUN: begin
                core_enable = 1'b1;
                if (core_ready) begin
                    run_cap = 1'b1;
                    rest_d  = RW'(REST_CYCLES - 1);
                    state_d = ST_REST;
                end
            end
            ST_REST: begin
                if (rest_q == '0) state_d = ST_DRAIN;
                else              rest_d  = rest_q - RW'(1);
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = ST_FILL;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            state_q   <= ST_FILL;
            cnt_q     <= '0;
            rest_q    <= '0;
            mode_q    <= 1'b0;
            key_len_q <= '0;
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                blk_q[i] <= '0;
                res_q[i] <= '0;
            end
            for (int i = 0; i < 8; i++) key_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rest_q  <= rest_d;
            if (fill_acc) begin
                blk_q[cnt_q] <= in_data;
                if (cnt_q == LAST_WORD) mode_q <= mode_encrypt;
            end
            if (key_wr_ok) begin
                key_q[key_wr_idx] <= key_wr_data;
                key_len_q         <= key_len_in;
            end
            if (run_cap) begin
                for (int i = 0; i < WORDS_PER_BLOCK; i++)
                    res_q[i] <= core_ciphertext[BLK_W-1-WORD_W*i -: WORD_W];
            end
        end
    end

    for (genvar g = 0; g < WORDS_PER_BLOCK; g++) begin : g_pt
        assign core_plaintext[BLK_W-1-WORD_W*g -: WORD_W] = blk_q[g];
    end

    assign core_encrypt    = mode_q;
    assign core_key_length = key_len_q;
    assign core_key0       = key_q[0];
    assign core_key1       = key_q[1];
    assign core_key2       = key_q[2];
    assign core_key3       = key_q[3];
    assign core_key4       = key_q[4];
    assign core_key5       = key_q[5];
    assign core_key6       = key_q[6];
    assign core_key7       = key_q[7];
    assign out_data        = res_q[cnt_q];
    assign busy            = !((state_q == ST_FILL) && (cnt_q == '0));

endmodule

// File: tb/tb_blowfish128_stream_ctrl.sv
// Bench for blowfish128_stream_ctrl: a reversible stand-in core, a word-queue model of
// the expected stream, and a per-cycle checker for data, handshakes and latencies.
module tb_blowfish128_stream_ctrl;
    import blowfish128_pkg::*;

    localparam int REST = 2;
    localparam int LAT  = 3;

    logic         Clk = 1'b0;
    logic         RstN = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         mode_encrypt = 1'b0;
    logic         key_wr_en = 1'b0;
    logic [2:0]   key_wr_idx = '0;
    logic [63:0]  key_wr_data = '0;
    logic [3:0]   key_len_in = '0;
    logic         core_enable, core_encrypt;
    logic [127:0] core_plaintext, core_ciphertext;
    logic [63:0]  core_key0, core_key1, core_key2, core_key3;
    logic [63:0]  core_key4, core_key5, core_key6, core_key7;
    logic [3:0]   core_key_length;
    logic         core_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         busy;

    always #5 Clk = ~Clk;

    blowfish128_stream_ctrl #(.WORD_W(32), .REST_CYCLES(REST)) dut (
        .Clk(Clk), .RstN(RstN),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode_encrypt(mode_encrypt),
        .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
        .key_len_in(key_len_in),
        .core_enable(core_enable), .core_encrypt(core_encrypt),
        .core_plaintext(core_plaintext),
        .core_key0(core_key0), .core_key1(core_key1), .core_key2(core_key2),
        .core_key3(core_key3), .core_key4(core_key4), .core_key5(core_key5),
        .core_key6(core_key6), .core_key7(core_key7),
        .core_key_length(core_key_length),
        .core_ciphertext(core_ciphertext), .core_ready(core_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    // Reversible stand-in cipher: whiten with keys 0/1 and key length, rotate by a byte.
    function automatic logic [127:0] bf_ref(input logic [127:0] d, input logic [63:0] k0,
                                            input logic [63:0] k1, input logic [3:0] kl,
                                            input logic enc);
        logic [127:0] kk, x;
        kk = {k0, k1 ^ {60'd0, kl}};
        if (enc) begin
            x = d ^ kk;
            return {x[119:0], x[127:120]};
        end
        x = {d[7:0], d[127:8]};
        return x ^ kk;
    endfunction

    int   en_cnt = 0;
    logic spur = 1'b0;
    always @(posedge Clk) en_cnt <= core_enable ? en_cnt + 1 : 0;
    assign core_ready      = (core_enable && en_cnt >= LAT) || spur;
    assign core_ciphertext = bf_ref(core_plaintext, core_key0, core_key1, core_key_length, core_encrypt);

    logic [63:0] dut_key [8];
    assign dut_key[0] = core_key0;
    assign dut_key[1] = core_key1;
    assign dut_key[2] = core_key2;
    assign dut_key[3] = core_key3;
    assign dut_key[4] = core_key4;
    assign dut_key[5] = core_key5;
    assign dut_key[6] = core_key6;
    assign dut_key[7] = core_key7;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chkw(nm, 128'(act), 128'(exp));
    endtask

    task automatic fail_msg(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got event expected none (t=%0t)", nm, $time);
    endtask

    // Model state: keys as the bench has effectively written them, pending blocks/words.
    logic [63:0]  m_key [8];
    logic [3:0]   m_klen = '0;
    logic [127:0] plain_q [$];
    logic         enc_q [$];
    logic [31:0]  exp_q [$];
    logic [31:0]  rx_q [$];

    int          acc_cnt = 0;
    int          gap = -1;
    bit          en_due = 1'b0;
    bit          post_rst = 1'b0;
    logic        prev_en = 1'b0, prev_ov = 1'b0, prev_or = 1'b0;
    logic [31:0] prev_od = '0;

    always @(negedge Clk) begin : cmp
        if (!RstN) begin
            chk1("in_ready_in_reset", in_ready, 1'b0);
            acc_cnt  = 0;
            gap      = -1;
            en_due   = 1'b0;
            post_rst = 1'b1;
            plain_q.delete();
            enc_q.delete();
            exp_q.delete();
            prev_en = 1'b0;
            prev_ov = 1'b0;
            prev_or = 1'b0;
        end else begin
            if (post_rst) begin
                chk1("rst_in_ready", in_ready, 1'b1);
                chk1("rst_core_enable", core_enable, 1'b0);
                chk1("rst_out_valid", out_valid, 1'b0);
                chk1("rst_busy", busy, 1'b0);
                post_rst = 1'b0;
            end
            if (en_due) begin
                chk1("enable_latency", core_enable, 1'b1);
                en_due = 1'b0;
            end
            if (core_enable && !prev_en) begin
                if (plain_q.size() == 0) fail_msg("unexpected_run");
                else begin
                    chkw("core_plaintext", core_plaintext, plain_q.pop_front());
                    chk1("core_encrypt", core_encrypt, enc_q.pop_front());
                    for (int i = 0; i < 8; i++) chkw("core_key", 128'(dut_key[i]), 128'(m_key[i]));
                    chkw("core_key_length", 128'(core_key_length), 128'(m_klen));
                end
            end
            if (gap >= 0) begin
                gap++;
                if (gap <= REST) chkw("rest_gap", 128'({core_enable, out_valid}), 128'(0));
                else begin
                    chk1("drain_start", out_valid, 1'b1);
                    gap = -1;
                end
            end
            if (core_enable && core_ready) gap = 0;
            chk1("in_ready_excl", in_ready && (core_enable || out_valid), 1'b0);
            if (prev_ov && !prev_or && out_valid)
                chkw("stall_stable", 128'(out_data), 128'(prev_od));
            if (out_valid) begin
                if (exp_q.size() == 0) fail_msg("unexpected_out");
                else begin
                    chkw("out_data", 128'(out_data), 128'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        rx_q.push_back(out_data);
                    end
                end
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                if (acc_cnt == 4) begin
                    acc_cnt = 0;
                    en_due  = 1'b1;
                end
            end
            prev_en = core_enable;
            prev_ov = out_valid;
            prev_or = out_ready;
            prev_od = out_data;
        end
    end

    // All driver tasks start and end just after a rising edge.
    task automatic drive_word(input logic [31:0] w);
        int  guard = 0;
        bit  done = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge Clk);
            if (in_ready) done = 1'b1;
            else if (++guard > 100) begin
                fail_msg("in_ready_timeout");
                done = 1'b1;
            end
        end
        @(posedge Clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] blk, input logic enc);
        logic [127:0] ct;
        plain_q.push_back(blk);
        enc_q.push_back(enc);
        ct = bf_ref(blk, m_key[0], m_key[1], m_klen, enc);
        for (int i = 0; i < 4; i++) exp_q.push_back(ct[127-32*i -: 32]);
        mode_encrypt = enc;
        for (int i = 0; i < 4; i++) drive_word(blk[127-32*i -: 32]);
    endtask

    task automatic key_write(input logic [2:0] idx, input logic [63:0] d,
                             input logic [3:0] len, input bit effective);
        key_wr_en   = 1'b1;
        key_wr_idx  = idx;
        key_wr_data = d;
        key_len_in  = len;
        @(posedge Clk); #1;
        key_wr_en = 1'b0;
        if (effective) begin
            m_key[idx] = d;
            m_klen     = len;
        end
    endtask

    // Collects four words; optionally stalls 5 cycles after the given transfer count
    // while offering junk input and a stray core_ready that must both be ignored.
    task automatic recv_block(input int stall_after);
        int n = 0;
        int guard = 0;
        bit stalled = 1'b0;
        out_ready = 1'b1;
        while (n < 4 && guard < 200) begin
            @(negedge Clk);
            guard++;
            if (out_valid && out_ready) begin
                n++;
                if (n == stall_after && !stalled) begin
                    @(posedge Clk); #1;
                    out_ready = 1'b0;
                    in_data   = 32'hdead_beef;
                    in_valid  = 1'b1;
                    spur      = 1'b1;
                    repeat (5) @(posedge Clk);
                    #1;
                    out_ready = 1'b1;
                    in_valid  = 1'b0;
                    spur      = 1'b0;
                    stalled   = 1'b1;
                    continue;
                end
            end
        end
        if (n < 4) fail_msg("drain_timeout");
        @(posedge Clk); #1;
    endtask

    task automatic chk_rx(input string nm, input logic [127:0] exp);
        logic [127:0] got = '0;
        if (rx_q.size() < 4) fail_msg(nm);
        else begin
            for (int i = 0; i < 4; i++) got = {got[95:0], rx_q.pop_front()};
            chkw(nm, got, exp);
        end
    endtask

    localparam logic [127:0] PT1 = 128'h123456ab_cd132536_123456ab_cd132536;
    localparam logic [127:0] CT1 = 128'h8f5fb3ea_25e9eb12_3456abcd_132534b8;
    localparam logic [127:0] PT5 = 128'h00000001_80000000_ffffffff_5a5aa5a5;

    logic [127:0] ct5;

    initial begin
        for (int i = 0; i < 8; i++) m_key[i] = '0;
        repeat (3) @(posedge Clk);
        #1 RstN = 1'b1;
        @(negedge Clk);
        chkw("reset_plaintext", core_plaintext, 128'd0);
        chkw("reset_key_length", 128'(core_key_length), 128'd0);
        chk1("reset_core_encrypt", core_encrypt, 1'b0);
        @(posedge Clk); #1;

        spur = 1'b1;
        repeat (2) @(posedge Clk);
        #1 spur = 1'b0;

        // Encrypt with key0 only, length 2.
        key_write(3'd0, 64'haabb_0918_2736_ccdd, 4'd2, 1'b1);
        send_block(PT1, 1'b1);
        @(negedge Clk);
        chkw("req_plaintext_literal", core_plaintext, PT1);
        chk1("req_encrypt_literal", core_encrypt, 1'b1);
        chk1("busy_in_run", busy, 1'b1);
        @(posedge Clk); #1;
        recv_block(0);
        chk_rx("cipher_literal", CT1);

        // Decrypt round trip with a key write issued during RUN that must be dropped.
        send_block(CT1, 1'b0);
        key_write(3'd0, 64'h0, 4'd5, 1'b0);
        recv_block(0);
        chk_rx("roundtrip_literal", PT1);

        // Output backpressure mid-drain.
        send_block(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1);
        recv_block(2);
        rx_q.delete();

        // Reset during RUN abandons the block and clears the keys.
        send_block(128'hcafef00d_0badc0de_13579bdf_2468ace0, 1'b1);
        @(posedge Clk); #1;
        RstN = 1'b0;
        @(posedge Clk); #1;
        RstN = 1'b1;
        for (int i = 0; i < 8; i++) m_key[i] = '0;
        m_klen = '0;
        rx_q.delete();

        // Fresh keys and a fresh block after reset, then its round trip.
        key_write(3'd0, 64'h0123_4567_89ab_cdef, 4'd3, 1'b1);
        key_write(3'd1, 64'hfedc_ba98_7654_3210, 4'd3, 1'b1);
        send_block(PT5, 1'b1);
        recv_block(0);
        ct5 = '0;
        if (rx_q.size() < 4) fail_msg("post_reset_rx");
        else for (int i = 0; i < 4; i++) ct5 = {ct5[95:0], rx_q.pop_front()};
        send_block(ct5, 1'b0);
        recv_block(3);
        chk_rx("post_reset_roundtrip", PT5);

        repeat (4) @(posedge Clk);
        #1;
        chkw("leftover_words", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        fail_msg("global_timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
